// File: rtl/mux7_rr_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux7_rr_sched_pkg
//  Description : Shared types and constants for the 7-input mux round-robin
//                scheduler (state encoding, requester count, idle code,
//                hold-counter width).
//  Revision    : 1.0 - initial release
// ============================================================================
package mux7_rr_sched_pkg;

    // Number of requesters sharing the mux (inputs e0..e6)
    localparam int N_REQ = 7;

    // Width of the grant hold counter; wide enough for HOLD_CYCLES up to 15
    localparam int CNT_W = 4;

    // Select code driven when no grant is live; the mux has no e7 input
    localparam logic [2:0] SEL_IDLE = 3'b111;

    // Scheduler states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage : mux7_rr_sched_pkg
`default_nettype wire

// File: rtl/mux7_rr_sched_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick7
//  Description : Combinational round-robin winner search over seven request
//                bits. Searches ptr+1, ptr+2, ... modulo 7 and returns the
//                first set request. All wrap-around logic lives here.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick7
    import mux7_rr_sched_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [2:0]       i_ptr,
    output logic [2:0]       o_idx,
    output logic             o_any
);

    // A pointer of 7 cannot occur in normal operation; fold it onto 6 so the
    // search still starts at e0 and never produces index 7.
    logic [3:0] w_base;
    logic [3:0] w_cand;

    assign w_base = (i_ptr == 3'd7) ? 4'd6 : {1'b0, i_ptr};

    // Rotate-and-priority search: first set request after the pointer wins
    always_comb begin
        o_idx  = 3'd0;
        o_any  = 1'b0;
        w_cand = 4'd0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = w_base + 4'(k);
            if (w_cand >= 4'(N_REQ)) begin
                w_cand = w_cand - 4'(N_REQ);
            end
            if (!o_any && i_req[w_cand[2:0]]) begin
                o_idx = w_cand[2:0];
                o_any = 1'b1;
            end
        end
    end

endmodule : rr_pick7
`default_nettype wire

// File: rtl/mux7_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : mux7_rr_sched
//  Description : Round-robin scheduler for a 7-input selector mux. Issues a
//                registered select code, one-hot grant and valid flag, bounds
//                each contended grant to HOLD_CYCLES cycles, and inserts a
//                one-cycle dead gap between consecutive grants.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux7_rr_sched
    import mux7_rr_sched_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [2:0]       sel,
    output logic             valid,
    output logic [N_REQ-1:0] gnt,
    output logic             busy
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [N_REQ-1:0] C_ONE     = {{(N_REQ-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [2:0]       r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_sel;
    logic             r_valid;
    logic [N_REQ-1:0] r_gnt;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [2:0]       w_ptr_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_sel_nxt;
    logic             w_valid_nxt;
    logic [N_REQ-1:0] w_gnt_nxt;

    logic [2:0]       w_idx;
    logic             w_any;
    logic             w_own_req;
    logic             w_other_req;
    logic             w_release;

    rr_pick7 u_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // The registered one-hot grant identifies the owner, so no index into req
    // is needed to test whether the owner or anyone else is still requesting.
    assign w_own_req   = |(req & r_gnt);
    assign w_other_req = |(req & ~r_gnt);
    assign w_release   = done || !w_own_req ||
                         ((r_cnt == C_CNT_MAX) && w_other_req);

    // State, pointer, counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= 3'd6;
            r_cnt   <= '0;
            r_sel   <= SEL_IDLE;
            r_valid <= 1'b0;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_valid <= w_valid_nxt;
            r_gnt   <= w_gnt_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Next-state and next-output decode: grant from IDLE, hold/release in
    // GRANT, single dead cycle in GAP
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_valid_nxt = r_valid;
        w_gnt_nxt   = r_gnt;
        case (r_state)
            ST_IDLE: begin
                if (en && w_any) begin
                    w_sel_nxt   = w_idx;
                    w_gnt_nxt   = C_ONE << w_idx;
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_ptr_nxt   = r_sel;
                    w_sel_nxt   = SEL_IDLE;
                    w_gnt_nxt   = '0;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_GAP;
                end else if (r_cnt != C_CNT_MAX) begin
                    // Saturating count lets a sole requester hold forever
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_GAP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_sel_nxt   = SEL_IDLE;
                w_gnt_nxt   = '0;
                w_valid_nxt = 1'b0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign sel   = r_sel;
    assign valid = r_valid;
    assign gnt   = r_gnt;
    assign busy  = r_busy;

endmodule : mux7_rr_sched
`default_nettype wire

// File: tb/tb_mux7_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux7_rr_sched
//  Description : Directed self-checking bench for mux7_rr_sched with
//                hand-computed expected outputs (HOLD_CYCLES = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux7_rr_sched;

    logic       clk;
    logic       rst;
    logic       en;
    logic [6:0] req;
    logic       done;
    logic [2:0] sel;
    logic       valid;
    logic [6:0] gnt;
    logic       busy;

    int n_checks;
    int n_fail;

    mux7_rr_sched #(.HOLD_CYCLES(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .req   (req),
        .done  (done),
        .sel   (sel),
        .valid (valid),
        .gnt   (gnt),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches
    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [2:0] e_sel, input logic e_valid,
                              input logic [6:0] e_gnt, input logic e_busy);
        check_eq({tag, ".sel"},   {5'd0, sel},   {5'd0, e_sel});
        check_eq({tag, ".valid"}, {7'd0, valid}, {7'd0, e_valid});
        check_eq({tag, ".gnt"},   {1'b0, gnt},   {1'b0, e_gnt});
        check_eq({tag, ".busy"},  {7'd0, busy},  {7'd0, e_busy});
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_gap_idle(input string tag);
        tick();
        expect_out({tag, ".gap"}, 3'b111, 1'b0, 7'h00, 1'b1);
        tick();
        expect_out({tag, ".idle"}, 3'b111, 1'b0, 7'h00, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst  = 1'b1;
        en   = 1'b1;
        req  = 7'h7F;
        done = 1'b0;
        tick();
        tick();
        expect_out("reset", 3'b111, 1'b0, 7'h00, 1'b0);

        // First IDLE edge after reset: ptr=6 so search starts at e0
        rst = 1'b0;
        expect_out("rel", 3'b111, 1'b0, 7'h00, 1'b0);
        tick();
        expect_out("first", 3'b000, 1'b1, 7'h01, 1'b1);

        // Contention e0/e6: four-cycle grants separated by GAP and IDLE
        req = 7'b1000001;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("e0hold", 3'b000, 1'b1, 7'h01, 1'b1);
        end
        expect_gap_idle("e0rel");
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_out("e6hold", 3'b110, 1'b1, 7'h40, 1'b1);
        end
        expect_gap_idle("e6rel");
        tick();
        expect_out("wrap_e0", 3'b000, 1'b1, 7'h01, 1'b1);

        // Sole requester e3: owner drops, e3 wins and keeps grant indefinitely
        req = 7'b0001000;
        expect_gap_idle("to_e3");
        tick();
        expect_out("e3", 3'b011, 1'b1, 7'h08, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            expect_out("e3sole", 3'b011, 1'b1, 7'h08, 1'b1);
        end

        // Early release via done in e2's second cycle
        req = 7'b0000000;
        tick();
        expect_out("e3drop", 3'b111, 1'b0, 7'h00, 1'b1);
        req = 7'b0000100;
        tick();
        expect_out("idle2", 3'b111, 1'b0, 7'h00, 1'b0);
        tick();
        expect_out("e2", 3'b010, 1'b1, 7'h04, 1'b1);
        tick();
        expect_out("e2c2", 3'b010, 1'b1, 7'h04, 1'b1);
        done = 1'b1;
        req  = 7'b0010100;
        tick();
        done = 1'b0;
        expect_out("e2done", 3'b111, 1'b0, 7'h00, 1'b1);
        tick();
        expect_out("e2idle", 3'b111, 1'b0, 7'h00, 1'b0);
        tick();
        expect_out("e4", 3'b100, 1'b1, 7'h10, 1'b1);

        // en=0 while e1 owns: grant completes, then IDLE holds until en=1
        req = 7'b0000010;
        expect_gap_idle("to_e1");
        tick();
        expect_out("e1", 3'b001, 1'b1, 7'h02, 1'b1);
        en  = 1'b0;
        req = 7'h7F;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("e1hold", 3'b001, 1'b1, 7'h02, 1'b1);
        end
        expect_gap_idle("e1rel");
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_out("en0idle", 3'b111, 1'b0, 7'h00, 1'b0);
        end
        en = 1'b1;
        tick();
        expect_out("en1_e2", 3'b010, 1'b1, 7'h04, 1'b1);

        // Synchronous reset in the middle of an e5 grant
        req = 7'b0100000;
        expect_gap_idle("to_e5");
        tick();
        expect_out("e5", 3'b101, 1'b1, 7'h20, 1'b1);
        rst = 1'b1;
        tick();
        expect_out("rst_mid", 3'b111, 1'b0, 7'h00, 1'b0);
        rst = 1'b0;
        req = 7'h7F;
        tick();
        expect_out("post_rst", 3'b000, 1'b1, 7'h01, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mux7_rr_sched
`default_nettype wire

// File: doc/mux7_rr_sched.md
# mux7_rr_sched

Round-robin scheduler that shares the 7-input selector mux (data inputs e0..e6, select bits b0..b2) between seven requesters. Each cycle it decides which requester owns the mux output. It drives the 3-bit select code, a one-hot grant vector and a valid flag. Each grant is held for a bounded time, and a one-cycle dead gap separates grants so the mux output never switches directly from one source to another.

## Interface
- HOLD_CYCLES, default 4: maximum cycles a grant is held while another request is pending; legal range 1..15.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  arbitration enable; 0 blocks new grants only.
- req  in  7  request vector; req[i] requests mux input e_i.
- done  in  1  current owner releases the grant early.
- sel  out  3  select code; sel[2] drives b0 (MSB), sel[1] drives b1, sel[0] drives b2 (LSB); value i selects e_i.
- valid  out  1  sel/gnt hold a live grant.
- gnt  out  7  one-hot grant; gnt[i]=1 iff valid and sel==i.
- busy  out  1  state is not IDLE.

## Operation
- Registered outputs. Reset values: sel=3'b111, valid=0, gnt=0, busy=0, state=IDLE, ptr=6, cnt=0.
- Code 3'b111 is the idle code. It never appears with valid=1, because the mux has no e7.
- States:
  - IDLE: sel=111, gnt=0, valid=0. If en=1 and req!=0, pick the winner idx and load sel=idx, gnt=1<<idx, valid=1, cnt=0, then go to GRANT. Otherwise stay in IDLE.
  - GRANT: outputs hold. Release when any of these holds in a cycle:
    - done=1;
    - req[idx]=0;
    - cnt==HOLD_CYCLES-1 and at least one other req bit is set.
    - On release: ptr<=idx, outputs go to idle values, next state GAP.
    - If none holds, cnt increments and saturates at HOLD_CYCLES-1. A sole requester keeps the grant indefinitely.
  - GAP: exactly one cycle, outputs at idle values, next state IDLE.
- Winner search order: ptr+1, ptr+2, ... modulo 7. Wrap 6→0; index 7 is never generated. First set req bit in that order wins.
- en=0 during GRANT: the current grant completes normally; no new grant is issued from IDLE.
- rst during GRANT or GAP: next cycle is the full reset state, ptr=6.

## Timing
- Grant latency: req sampled in IDLE at edge t gives valid=1 after edge t+1.
- Release: condition at edge t gives valid=0 after edge t+1. GAP occupies the next cycle, IDLE the one after, and a new grant appears at the earliest 3 cycles after the release cycle.
- Minimum grant length 1 cycle. Maximum grant length while contended is HOLD_CYCLES cycles.
- done together with cnt limit: single release, no double-counting.
- done asserted in IDLE or GAP: ignored.
- req changes in GAP: sampled only in the following IDLE cycle.
- busy=1 in GRANT and GAP.

## Structure
- Shared package holds:
  - state encoding (IDLE, GRANT, GAP);
  - N_REQ=7;
  - SEL_IDLE=3'b111;
  - count width of 4 bits.
- One natural sub-module: rr_pick7. It is combinational, takes (req[6:0], ptr[2:0]) and returns (idx[2:0], any). It does the rotate-and-priority search modulo 7. It is the only place wrap-around logic lives.
- The top level holds the FSM, ptr, cnt and the output registers.

## Test plan
- Reset with req=7'h7F:
  - one cycle after reset release: sel=111, valid=0, gnt=0;
  - next: sel=0, gnt=7'h01.
- Contention, HOLD_CYCLES=4, req=7'b1000001 held:
  - e0 granted for 4 cycles, then GAP, IDLE, then e6 (sel=110) for 4 cycles;
  - then wrap back to e0, never sel=111 with valid=1.
- Sole requester: req=7'b0001000 for 20 cycles → sel=011 and valid held continuously; cnt saturates; no GAP.
- Early release:
  - e2 granted and done pulsed in its 2nd cycle → valid drops the next cycle;
  - with req=7'b0010100, the next winner is e4.
- en=0 while e1 granted:
  - the e1 grant runs to its limit or done;
  - afterwards the block stays in IDLE with req=7'h7F until en=1.
- Synchronous reset mid-GRANT (sel=101) → next cycle all outputs at reset values; next grant starts search at e0.
